// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and sizes for mini_calc_ctrl
// Contents: state_t (LOAD_A, LOAD_B, EXEC, DONE), op_t (OP_ADD, OP_SUB, OP_MUL, OP_RSVD),
//           DATA_W, RES_W, MUL_ITERS and the derived MUL counter width CNT_W.
package calc_pkg;

   localparam int DATA_W    = 8;
   localparam int RES_W     = 16;
   localparam int MUL_ITERS = 8;
   localparam int CNT_W     = $clog2(MUL_ITERS);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      EXEC   = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

endpackage

// File: rtl/mini_calc_ctrl_if.sv
// rtl/mini_calc_ctrl_if.sv - operator-side signal bundle of mini_calc_ctrl
// Signals: sw_data[7:0], op_sel[1:0], btn_enter, btn_clear  (driven by master)
//          result[15:0], result_valid, busy, carry, overflow, err, state_o[1:0]  (driven by slave)
// Modports: master (switch/button side), slave (mini_calc_ctrl).
interface mini_calc_ctrl_if;
   import calc_pkg::*;

   logic [DATA_W-1:0] sw_data;
   logic [1:0]        op_sel;
   logic              btn_enter;
   logic              btn_clear;
   logic [RES_W-1:0]  result;
   logic              result_valid;
   logic              busy;
   logic              carry;
   logic              overflow;
   logic              err;
   logic [1:0]        state_o;

   modport master (
      output sw_data, op_sel, btn_enter, btn_clear,
      input  result, result_valid, busy, carry, overflow, err, state_o
   );

   modport slave (
      input  sw_data, op_sel, btn_enter, btn_clear,
      output result, result_valid, busy, carry, overflow, err, state_o
   );

endinterface

// File: rtl/eight_bit_adder.sv
// rtl/eight_bit_adder.sv - 8-bit ripple adder with carry in/out
// Ports: a[7:0], b[7:0], ci in; sum[7:0], co out.
module eight_bit_adder
   import calc_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              ci,
   output logic [DATA_W-1:0] sum,
   output logic              co
);

   assign {co, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};

endmodule

// File: rtl/mini_calc_ctrl.sv
// rtl/mini_calc_ctrl.sv - two-operand ADD/SUB/MUL calculator controller
// Ports: clk, reset (synchronous, active high), bus (mini_calc_ctrl_if.slave).
// Build option: CALC_MUL_EN enables the 8-cycle shift-add multiplier for op 10;
//               without it op 10 is treated as reserved and the MUL state is not built.
module mini_calc_ctrl
   import calc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   mini_calc_ctrl_if.slave bus
);

   state_t            state, state_next;
   logic [DATA_W-1:0] a_reg, b_reg;
   op_t               op_reg;
   logic [RES_W-1:0]  result_q;
   logic              carry_q, ovf_q, err_q;

   logic [DATA_W-1:0] add_a, add_b, add_sum;
   logic              add_ci, add_co;
   logic              exec_last;
   logic [RES_W-1:0]  res_next;
   logic              carry_next, ovf_next, err_next;

`ifdef CALC_MUL_EN
   // prod holds {partial high byte, remaining multiplier bits}; each cycle the
   // adder adds A (or 0) into the high byte and the whole word shifts right.
   logic [CNT_W-1:0]  mul_cnt;
   logic [RES_W-1:0]  prod;
   logic [RES_W-1:0]  prod_next;
`endif

   // The one and only adder; every op steers its operands.
   eight_bit_adder u_adder (
      .a   (add_a),
      .b   (add_b),
      .ci  (add_ci),
      .sum (add_sum),
      .co  (add_co)
   );

   always_comb begin
      add_a  = a_reg;
      add_b  = b_reg;
      add_ci = 1'b0;
      case (op_reg)
         OP_SUB: begin
            add_b  = ~b_reg;
            add_ci = 1'b1;
         end
`ifdef CALC_MUL_EN
         OP_MUL: begin
            add_a = prod[RES_W-1:DATA_W];
            add_b = prod[0] ? a_reg : '0;
         end
`endif
         default: ;
      endcase
   end

`ifdef CALC_MUL_EN
   assign prod_next = {add_co, add_sum, prod[DATA_W-1:1]};
   assign exec_last = (state == EXEC) &&
                      ((op_reg != OP_MUL) || (mul_cnt == CNT_W'(MUL_ITERS - 1)));
`else
   assign exec_last = (state == EXEC);
`endif

   always_comb begin
      res_next   = '0;
      carry_next = 1'b0;
      ovf_next   = 1'b0;
      err_next   = 1'b0;
      case (op_reg)
         OP_ADD: begin
            res_next   = {{(RES_W-DATA_W-1){1'b0}}, add_co, add_sum};
            carry_next = add_co;
         end
         OP_SUB: begin
            res_next   = {{(RES_W-DATA_W){add_sum[DATA_W-1]}}, add_sum};
            carry_next = add_co;
            ovf_next   = (a_reg[DATA_W-1] != b_reg[DATA_W-1]) &&
                         (add_sum[DATA_W-1] != a_reg[DATA_W-1]);
         end
`ifdef CALC_MUL_EN
         OP_MUL: res_next = prod_next;
`endif
         default: err_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD_A;
      end else begin
         state <= state_next;
      end
   end

   // btn_clear is checked first so it wins over a simultaneous btn_enter.
   always_comb begin
      state_next = state;
      if (bus.btn_clear) begin
         state_next = LOAD_A;
      end else begin
         case (state)
            LOAD_A:  if (bus.btn_enter) state_next = LOAD_B;
            LOAD_B:  if (bus.btn_enter) state_next = EXEC;
            EXEC:    if (exec_last)     state_next = DONE;
            DONE:    if (bus.btn_enter) state_next = LOAD_A;
            default: state_next = LOAD_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= OP_ADD;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef CALC_MUL_EN
         mul_cnt  <= '0;
         prod     <= '0;
`endif
      end else if (bus.btn_clear) begin
         a_reg    <= '0;
         b_reg    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef CALC_MUL_EN
         mul_cnt  <= '0;
         prod     <= '0;
`endif
      end else begin
         case (state)
            LOAD_A: begin
               if (bus.btn_enter) a_reg <= bus.sw_data;
            end
            LOAD_B: begin
               if (bus.btn_enter) begin
                  b_reg  <= bus.sw_data;
                  op_reg <= op_t'(bus.op_sel);
`ifdef CALC_MUL_EN
                  mul_cnt <= '0;
                  prod    <= {{DATA_W{1'b0}}, bus.sw_data};
`endif
               end
            end
            EXEC: begin
`ifdef CALC_MUL_EN
               if (op_reg == OP_MUL) begin
                  prod    <= prod_next;
                  mul_cnt <= mul_cnt + CNT_W'(1);
               end
`endif
               if (exec_last) begin
                  result_q <= res_next;
                  carry_q  <= carry_next;
                  ovf_q    <= ovf_next;
                  err_q    <= err_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result       = result_q;
   assign bus.carry        = carry_q;
   assign bus.overflow     = ovf_q;
   assign bus.err          = err_q;
   assign bus.busy         = (state == EXEC);
   assign bus.result_valid = (state == DONE);
   assign bus.state_o      = state;

endmodule

// File: tb/tb_mini_calc_ctrl.sv
// tb/tb_mini_calc_ctrl.sv - directed self-checking bench for mini_calc_ctrl
module tb_mini_calc_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   lat, bcnt, vcnt;

`ifdef CALC_MUL_EN
   localparam logic [1:0] MID_OP   = 2'b10;
   localparam int         MID_WAIT = 3;
`else
   localparam logic [1:0] MID_OP   = 2'b00;
   localparam int         MID_WAIT = 0;
`endif

   always #5 clk = ~clk;

   mini_calc_ctrl_if bus ();

   mini_calc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Enters A then B/op; returns one step after the B-capture edge.
   task automatic load_ab(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      bus.sw_data   = a;
      bus.btn_enter = 1'b1;
      step();
      bus.btn_enter = 1'b0;
      check("a_to_load_b", {30'd0, bus.state_o}, 32'd1);
      bus.sw_data   = b;
      bus.op_sel    = op;
      bus.btn_enter = 1'b1;
      step();
      bus.btn_enter = 1'b0;
   endtask

   // lat counts edges from the B-enter cycle to result_valid; poke presses enter in EXEC.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input bit poke, output int l, output int bc);
      load_ab(a, b, op);
      l  = 1;
      bc = 0;
      if (poke) bus.btn_enter = 1'b1;
      while (bus.result_valid !== 1'b1 && l < 40) begin
         if (bus.busy === 1'b1) bc++;
         step();
         bus.btn_enter = 1'b0;
         l++;
      end
      check("valid_reached", {31'd0, bus.result_valid}, 32'd1);
   endtask

   task automatic ack(input logic [15:0] exp_res);
      bus.btn_enter = 1'b1;
      step();
      bus.btn_enter = 1'b0;
      check("ack_state", {30'd0, bus.state_o}, 32'd0);
      check("ack_valid_low", {31'd0, bus.result_valid}, 32'd0);
      check("ack_result_hold", {16'd0, bus.result}, {16'd0, exp_res});
   endtask

   task automatic check_res(input string tag, input logic [15:0] r, input logic c,
                            input logic o, input logic e);
      check({tag, "_result"}, {16'd0, bus.result}, {16'd0, r});
      check({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, c});
      check({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, o});
      check({tag, "_err"}, {31'd0, bus.err}, {31'd0, e});
   endtask

   initial begin
      reset         = 1'b1;
      bus.sw_data   = '0;
      bus.op_sel    = '0;
      bus.btn_enter = 1'b0;
      bus.btn_clear = 1'b0;
      step();
      step();
      check("rst_state", {30'd0, bus.state_o}, 32'd0);
      check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step();

      // ADD 200 + 100
      run_op(8'd200, 8'd100, 2'b00, 1'b0, lat, bcnt);
      check_res("add", 16'h012C, 1'b1, 1'b0, 1'b0);
      check("add_latency", lat, 32'd2);
      check("add_busy_cycles", bcnt, 32'd1);
      step();
      step();
      check("done_hold_state", {30'd0, bus.state_o}, 32'd3);
      check("done_hold_result", {16'd0, bus.result}, 32'h012C);
      ack(16'h012C);
      check("ack_carry_hold", {31'd0, bus.carry}, 32'd1);

      // SUB 5 - 9
      run_op(8'd5, 8'd9, 2'b01, 1'b0, lat, bcnt);
      check_res("sub_neg", 16'hFFFC, 1'b0, 1'b0, 1'b0);
      check("sub_latency", lat, 32'd2);
      ack(16'hFFFC);

      // SUB 0x64 - 0x9C overflows
      run_op(8'h64, 8'h9C, 2'b01, 1'b0, lat, bcnt);
      check_res("sub_ovf", 16'hFFC8, 1'b0, 1'b1, 1'b0);
      ack(16'hFFC8);

      // SUB 10 - 3 with btn_enter pressed during EXEC
      run_op(8'd10, 8'd3, 2'b01, 1'b1, lat, bcnt);
      check_res("sub_pos", 16'h0007, 1'b1, 1'b0, 1'b0);
      check("enter_in_exec_state", {30'd0, bus.state_o}, 32'd3);
      ack(16'h0007);

      // reserved op 11
      run_op(8'd7, 8'd9, 2'b11, 1'b0, lat, bcnt);
      check_res("rsvd", 16'h0000, 1'b0, 1'b0, 1'b1);
      check("rsvd_latency", lat, 32'd2);
      ack(16'h0000);
      check("rsvd_err_hold", {31'd0, bus.err}, 32'd1);

`ifdef CALC_MUL_EN
      run_op(8'd255, 8'd255, 2'b10, 1'b0, lat, bcnt);
      check_res("mul_ff", 16'hFE01, 1'b0, 1'b0, 1'b0);
      check("mul_latency", lat, 32'd9);
      check("mul_busy_cycles", bcnt, 32'd8);
      ack(16'hFE01);
      run_op(8'd13, 8'd11, 2'b10, 1'b1, lat, bcnt);
      check_res("mul_13x11", 16'h008F, 1'b0, 1'b0, 1'b0);
      check("mul2_latency", lat, 32'd9);
      ack(16'h008F);
`else
      run_op(8'd6, 8'd7, 2'b10, 1'b0, lat, bcnt);
      check_res("mul_disabled", 16'h0000, 1'b0, 1'b0, 1'b1);
      check("mul_disabled_latency", lat, 32'd2);
      ack(16'h0000);
`endif

      // ADD 1 + 2 clears err
      run_op(8'd1, 8'd2, 2'b00, 1'b0, lat, bcnt);
      check_res("add_small", 16'h0003, 1'b0, 1'b0, 1'b0);
      ack(16'h0003);

      // btn_clear during EXEC
      load_ab(8'h0F, 8'h0F, MID_OP);
      for (int i = 0; i < MID_WAIT; i++) step();
      check("mid_busy", {31'd0, bus.busy}, 32'd1);
      bus.btn_clear = 1'b1;
      step();
      bus.btn_clear = 1'b0;
      check("clr_state", {30'd0, bus.state_o}, 32'd0);
      check("clr_result", {16'd0, bus.result}, 32'd0);
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.result_valid !== 1'b0) vcnt++;
         step();
      end
      check("clr_valid_never", vcnt, 32'd0);

      // btn_enter together with btn_clear in LOAD_B
      bus.sw_data   = 8'h11;
      bus.btn_enter = 1'b1;
      step();
      check("ec_load_b", {30'd0, bus.state_o}, 32'd1);
      bus.sw_data   = 8'h22;
      bus.btn_clear = 1'b1;
      step();
      bus.btn_enter = 1'b0;
      bus.btn_clear = 1'b0;
      check("ec_state", {30'd0, bus.state_o}, 32'd0);
      check("ec_busy", {31'd0, bus.busy}, 32'd0);
      step();
      step();
      check("ec_idle_state", {30'd0, bus.state_o}, 32'd0);
      check("ec_idle_valid", {31'd0, bus.result_valid}, 32'd0);

      // reset during EXEC
      run_op(8'd40, 8'd2, 2'b00, 1'b0, lat, bcnt);
      check_res("pre_rst", 16'h002A, 1'b0, 1'b0, 1'b0);
      ack(16'h002A);
      load_ab(8'h0F, 8'h0F, MID_OP);
      for (int i = 0; i < MID_WAIT; i++) step();
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_state", {30'd0, bus.state_o}, 32'd0);
      check("rst_mid_busy_low", {31'd0, bus.busy}, 32'd0);
      check_res("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.result_valid !== 1'b0) vcnt++;
         step();
      end
      check("rst_mid_valid_never", vcnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mini_calc_ctrl.md
MINI_CALC_CTRL -- requirements
Module: mini_calc_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs: sw_data  in  8  operand switches (unsigned for ADD/MUL, two's complement for SUB); op_sel  in  2  00 ADD, 01 SUB, 10 MUL, 11 reserved; btn_enter  in  1  debounced single-cycle pulse; btn_clear  in  1  debounced single-cycle pulse.
REQ-003 The block SHALL have these outputs: result  out  16  registered result; result_valid  out  1  result held and valid; busy  out  1  EXEC in progress; carry  out  1  adder carry-out of last ADD/SUB; overflow  out  1  signed overflow of last SUB; err  out  1  reserved or disabled op; state_o  out  2  current FSM state.

Function
REQ-004 The FSM SHALL have states LOAD_A=0, LOAD_B=1, EXEC=2, DONE=3, and state_o SHALL equal the current state.
REQ-005 In LOAD_A, btn_enter SHALL capture sw_data into A and move to LOAD_B.
REQ-006 In LOAD_B, btn_enter SHALL capture sw_data into B and op_sel into op, clear the MUL iteration counter, and move to EXEC.
REQ-007 ADD SHALL take 1 EXEC cycle: result={7'b0,Cout,Sum} with Ci=0; carry=Cout; overflow=0.
REQ-008 SUB SHALL take 1 EXEC cycle with the adder driven by B inverted and Ci=1: result=Sum sign-extended to 16 bits; carry=Cout (1 = no borrow); overflow=(A[7]!=B[7])&&(Sum[7]!=A[7]).
REQ-009 MUL SHALL take exactly 8 EXEC cycles of shift-add, one multiplier bit per cycle, LSB first; result SHALL be the 16-bit unsigned product; carry=0; overflow=0.
REQ-010 A reserved op SHALL take 1 EXEC cycle and set result=0, err=1, carry=0, overflow=0.
REQ-011 All arithmetic SHALL go through a single 8-bit adder instance; no other adder SHALL be inferred.
REQ-012 At the last EXEC cycle, the result and flags SHALL be registered and the FSM SHALL move to DONE; result_valid rises n+1 cycles after the B-capture edge (n=1 ADD/SUB/reserved, n=8 MUL).
REQ-013 busy SHALL be 1 exactly while state==EXEC; result_valid SHALL be 1 exactly while state==DONE.
REQ-014 In DONE, result and flags SHALL hold; btn_enter SHALL move to LOAD_A and clear result_valid, while result, carry, overflow and err hold until the next DONE entry.
REQ-015 btn_enter SHALL be ignored in EXEC.
REQ-016 btn_clear SHALL, in any state, move to LOAD_A on the next edge, zero A, B, result, the flags and the counter, and abort any EXEC.
REQ-017 btn_clear SHALL take priority over a simultaneous btn_enter.

Reset
REQ-018 Reset SHALL force state=LOAD_A and set result=0, result_valid=0, busy=0, carry=0, overflow=0, err=0, and A, B, op and the counter to 0.
REQ-019 Reset asserted mid-EXEC SHALL abort the operation with no partial result visible afterwards.

Configuration
REQ-020 With CALC_MUL_EN defined, op 10 SHALL perform MUL; without it, op 10 SHALL behave as reserved (REQ-010), and the MUL counter and shift registers SHALL be absent.

Structure
REQ-021 A shared package calc_pkg SHALL hold the state enum, the op enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD), DATA_W=8, RES_W=16 and MUL_ITERS=8.
REQ-022 The single natural sub-module SHALL be the team's existing eight_bit_adder, instantiated once and muxed between ADD, SUB and MUL.

Verification
REQ-023 ADD: A=200, B=100, op=00 -> result=0x012C, carry=1, result_valid 2 cycles after B enter.
REQ-024 SUB: A=5, B=9 -> result=0xFFFC, carry=0, overflow=0; A=0x64, B=0x9C -> result=0xFFC8, overflow=1.
REQ-025 MUL (CALC_MUL_EN): A=255, B=255 -> result=0xFE01, busy high exactly 8 cycles, result_valid 9 cycles after B enter.
REQ-026 btn_clear at MUL iteration 4 -> state_o=0 next cycle, result=0, result_valid never asserted.
REQ-027 op=11, or op=10 without CALC_MUL_EN -> err=1, result=0 after 1 EXEC cycle; btn_enter with btn_clear in the same cycle in LOAD_B -> LOAD_A, nothing captured.
